// File: rtl/delayw_pkg.sv
// Shared definitions for the sample-indexed delay line: FSM encoding and
// default geometry.
package delayw_pkg;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DW_DEF        = 8;
    localparam int MAX_DEPTH_DEF = 16;

endpackage

// File: rtl/delayw_ram.sv
// Single-port delay buffer: synchronous write, registered read that returns
// the contents from before a same-cycle write.
module delayw_ram
    import delayw_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int MAX_DEPTH = MAX_DEPTH_DEF,
    parameter int AW        = $clog2(MAX_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rd_clr,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [MAX_DEPTH];

    // Storage write; no reset, the controller zeroes it by flushing.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    // Read register: sees the old word when the same address is written.
    always_ff @(posedge i_clk) begin
        if (i_rd_clr) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/delayw_ctrl.sv
// Configurable sample-indexed delay: every accepted sample yields the sample
// accepted D acceptances earlier. A depth change zeroes the whole buffer,
// so the first D outputs after any flush are zero.
module delayw_ctrl
    import delayw_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int MAX_DEPTH = MAX_DEPTH_DEF,
    parameter int AW        = $clog2(MAX_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cfg_we,
    input  logic [AW:0]   i_cfg_depth,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_busy,
    output logic [AW:0]   o_depth
);

    state_t        state_q;
    logic [AW-1:0] flush_cnt_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   depth_q;
    logic          ready_q;
    logic          busy_q;
    logic          vld_p1;
    logic          accept_p0;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    // Out-of-range requests are pulled into 1..MAX_DEPTH.
    function automatic logic [AW:0] clamp_depth(input logic [AW:0] d);
        if (d == '0) begin
            return (AW+1)'(1);
        end else if (d > (AW+1)'(MAX_DEPTH)) begin
            return (AW+1)'(MAX_DEPTH);
        end
        return d;
    endfunction

    assign accept_p0 = i_valid && ready_q;

    // Flush zero-writes and sample writes share the single RAM port.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ptr_q;
        ram_wdata = i_data;
        if (!i_reset) begin
            if (state_q == ST_FLUSH) begin
                ram_we    = 1'b1;
                ram_addr  = flush_cnt_q;
                ram_wdata = '0;
            end else if (accept_p0) begin
                ram_we = 1'b1;
            end
        end
    end

    delayw_ram #(
        .DW        (DW),
        .MAX_DEPTH (MAX_DEPTH),
        .AW        (AW)
    ) u_ram (
        .i_clk    (i_clk),
        .i_rd_clr (i_reset),
        .i_we     (ram_we),
        .i_re     (accept_p0 && !i_reset),
        .i_addr   (ram_addr),
        .i_wdata  (ram_wdata),
        .o_rdata  (o_data)
    );

    // FLUSH/RUN controller with pointer, depth and registered handshakes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            ptr_q       <= '0;
            depth_q     <= (AW+1)'(1);
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            vld_p1      <= 1'b0;
        end else begin
            // stage p0 -> p1: read data lands in the RAM register with this valid
            vld_p1 <= accept_p0;
            case (state_q)
                ST_FLUSH: begin
                    if (i_cfg_we) begin
                        depth_q     <= clamp_depth(i_cfg_depth);
                        ptr_q       <= '0;
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == AW'(MAX_DEPTH - 1)) begin
                        state_q     <= ST_RUN;
                        flush_cnt_q <= '0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (accept_p0) begin
                        if ({1'b0, ptr_q} == depth_q - (AW+1)'(1)) begin
                            ptr_q <= '0;
                        end else begin
                            ptr_q <= ptr_q + AW'(1);
                        end
                    end
                    // A same-cycle sample has already used the old depth above.
                    if (i_cfg_we) begin
                        depth_q     <= clamp_depth(i_cfg_depth);
                        ptr_q       <= '0;
                        flush_cnt_q <= '0;
                        state_q     <= ST_FLUSH;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_FLUSH;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_valid = vld_p1;
    assign o_depth = depth_q;

endmodule

// File: tb/tb_delayw_ctrl.sv
// Directed bench for delayw_ctrl: table-driven sample vectors plus
// hand-written sequences for flush, clamp, collision and reset cases.
module tb_delayw_ctrl;

    localparam int DW        = 8;
    localparam int MAX_DEPTH = 16;
    localparam int AW        = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW:0]   cfg_depth;
    logic          valid;
    logic          ready;
    logic [DW-1:0] din;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [AW:0]   depth;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ev;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    delayw_ctrl #(
        .DW        (DW),
        .MAX_DEPTH (MAX_DEPTH),
        .AW        (AW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_cfg_we    (cfg_we),
        .i_cfg_depth (cfg_depth),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_data      (din),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_busy      (busy),
        .o_depth     (depth)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at a falling edge; return at the next falling
    // edge so outputs reflect the rising edge that consumed them.
    task automatic cycle(input logic r, input logic v, input logic we,
                         input logic [AW:0] dep, input logic [DW-1:0] d);
        rst       = r;
        valid     = v;
        cfg_we    = we;
        cfg_depth = dep;
        din       = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        cycle(1'b0, 1'b1, 1'b0, '0, d);
    endtask

    task automatic load_depth(input logic [AW:0] dep);
        cycle(1'b0, 1'b0, 1'b1, dep, '0);
    endtask

    // Bounded wait for the flush to end; also counts stray output pulses.
    task automatic wait_idle(output int n, output int stray);
        n     = 0;
        stray = 0;
        while (busy === 1'b1 && n < 100) begin
            if (out_valid !== 1'b0) stray++;
            n++;
            idle();
        end
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            send_or_idle(vecs[i].v, vecs[i].d);
            chk($sformatf("%s[%0d].valid", tag, i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("%s[%0d].data", tag, i), 32'(out_data), 32'(vecs[i].ed));
        end
        vecs.delete();
    endtask

    task automatic send_or_idle(input logic v, input logic [DW-1:0] d);
        cycle(1'b0, v, 1'b0, '0, d);
    endtask

    initial begin
        int n;
        int stray;

        rst = 1'b1; valid = 1'b0; cfg_we = 1'b0; cfg_depth = '0; din = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset state and idle flush
        chk("rst.busy", 32'(busy), 32'(1));
        chk("rst.ready", 32'(ready), 32'(0));
        chk("rst.valid", 32'(out_valid), 32'(0));
        chk("rst.data", 32'(out_data), 32'(0));
        chk("rst.depth", 32'(depth), 32'(1));
        wait_idle(n, stray);
        chk("rst.flush_cycles", 32'(n), 32'(16));
        chk("rst.flush_stray", 32'(stray), 32'(0));
        chk("idle.ready", 32'(ready), 32'(1));
        chk("idle.depth", 32'(depth), 32'(1));
        chk("idle.valid", 32'(out_valid), 32'(0));
        chk("idle.data", 32'(out_data), 32'(0));

        // Depth 3, back-to-back
        load_depth(5'd3);
        chk("d3.depth", 32'(depth), 32'(3));
        chk("d3.busy", 32'(busy), 32'(1));
        chk("d3.ready", 32'(ready), 32'(0));
        wait_idle(n, stray);
        chk("d3.flush_cycles", 32'(n), 32'(16));
        vecs.push_back('{1'b1, 8'd1, 1'b1, 8'd0});
        vecs.push_back('{1'b1, 8'd2, 1'b1, 8'd0});
        vecs.push_back('{1'b1, 8'd3, 1'b1, 8'd0});
        vecs.push_back('{1'b1, 8'd4, 1'b1, 8'd1});
        vecs.push_back('{1'b1, 8'd5, 1'b1, 8'd2});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd2});
        run_vecs("d3");

        // Depth 2, gapped input
        load_depth(5'd2);
        wait_idle(n, stray);
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 8'h00});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'hFF, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 8'h5A, 1'b1, 8'h00});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 8'h11, 1'b1, 8'hA5});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'hA5});
        run_vecs("gap");

        // Clamp low and high, then full-depth wrap
        load_depth(5'd0);
        chk("clamp0.depth", 32'(depth), 32'(1));
        wait_idle(n, stray);
        load_depth(5'd20);
        chk("clamp20.depth", 32'(depth), 32'(16));
        wait_idle(n, stray);
        for (int i = 0; i < 34; i++) begin
            vecs.push_back('{1'b1, 8'(i), 1'b1, (i >= 16) ? 8'(i - 16) : 8'd0});
        end
        run_vecs("wrap");

        // Config strobe on an accepting cycle, then a restart mid-flush
        load_depth(5'd2);
        wait_idle(n, stray);
        send(8'd7);
        send(8'd8);
        cycle(1'b0, 1'b1, 1'b1, 5'd4, 8'd9);
        chk("coll.valid", 32'(out_valid), 32'(1));
        chk("coll.data", 32'(out_data), 32'(7));
        chk("coll.depth", 32'(depth), 32'(4));
        chk("coll.busy", 32'(busy), 32'(1));
        chk("coll.ready", 32'(ready), 32'(0));
        for (int i = 0; i < 5; i++) idle();
        chk("coll.busy_mid", 32'(busy), 32'(1));
        load_depth(5'd2);
        chk("restart.depth", 32'(depth), 32'(2));
        wait_idle(n, stray);
        chk("restart.flush_cycles", 32'(n), 32'(16));
        chk("restart.stray", 32'(stray), 32'(0));
        vecs.push_back('{1'b1, 8'd1, 1'b1, 8'd0});
        vecs.push_back('{1'b1, 8'd2, 1'b1, 8'd0});
        vecs.push_back('{1'b1, 8'd3, 1'b1, 8'd1});
        run_vecs("post_flush");

        // Reset while a sample is being accepted
        cycle(1'b1, 1'b1, 1'b1, 5'd5, 8'h44);
        chk("midrst.valid", 32'(out_valid), 32'(0));
        chk("midrst.depth", 32'(depth), 32'(1));
        chk("midrst.data", 32'(out_data), 32'(0));
        chk("midrst.busy", 32'(busy), 32'(1));
        wait_idle(n, stray);
        chk("midrst.flush_cycles", 32'(n), 32'(16));
        vecs.push_back('{1'b1, 8'h55, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 8'h66, 1'b1, 8'h55});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h55});
        vecs.push_back('{1'b1, 8'h77, 1'b1, 8'h66});
        run_vecs("d1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
